// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - instruction memory loader: header/payload/checksum stream into RAM, HALT padding, CPU hold
module imem_loader #(
    parameter int                    DATA_WIDTH = 10,
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DEPTH      = 1024,
    parameter int                    FILL_HALT  = 1,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 10'b0010000010
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_hold,
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_LOAD, S_CHECK, S_FILL, S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

    state_t                  state_q;
    logic                    in_ready_q;
    logic                    mem_we_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    error_q;
    logic                    cpu_hold_q;
    logic [ADDR_WIDTH:0]     word_count_q;
    logic [ADDR_WIDTH:0]     n_q;
    logic [ADDR_WIDTH:0]     fill_q;
    logic [DATA_WIDTH-1:0]   acc_q;
    logic                    accept;

    // in_ready_q is only ever high in HEADER/LOAD/CHECK, so it doubles as the state gate
    assign accept = in_valid & in_ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_hold_q   <= 1'b1;
            word_count_q <= '0;
            n_q          <= '0;
            fill_q       <= '0;
            acc_q        <= '0;
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q      <= S_HEADER;
                        in_ready_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        cpu_hold_q   <= 1'b1;
                        error_q      <= 1'b0;
                        word_count_q <= '0;
                        acc_q        <= '0;
                    end
                end
                S_HEADER: begin
                    if (accept) begin
                        n_q     <= (ADDR_WIDTH+1)'(in_data);
                        state_q <= (in_data == '0) ? S_CHECK : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        mem_we_q     <= 1'b1;
                        mem_addr_q   <= word_count_q[ADDR_WIDTH-1:0];
                        mem_wdata_q  <= in_data;
                        acc_q        <= acc_q + in_data;
                        word_count_q <= word_count_q + ONE;
                        if (word_count_q + ONE == n_q) begin
                            state_q <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (in_data != acc_q) begin
                            state_q <= S_IDLE;
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (FILL_HALT == 1 && n_q < DEPTH_C) begin
                            // first pad write goes out with the FILL entry so the last one lands just before DONE
                            state_q     <= S_FILL;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= n_q[ADDR_WIDTH-1:0];
                            mem_wdata_q <= HALT_WORD;
                            fill_q      <= n_q + ONE;
                        end else begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end
                    end
                end
                S_FILL: begin
                    if (fill_q == DEPTH_C) begin
                        state_q    <= S_DONE;
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                    end else begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= fill_q[ADDR_WIDTH-1:0];
                        mem_wdata_q <= HALT_WORD;
                        fill_q      <= fill_q + ONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign cpu_hold   = cpu_hold_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed bench driving a no-fill and a fill loader from one shared stream
module tb_imem_loader;

    localparam logic [9:0] HALT = 10'b0010000010;

    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [9:0]  in_data;
    logic        in_ready0, mem_we0, busy0, done0, error0, cpu_hold0;
    logic [9:0]  mem_addr0, mem_wdata0;
    logic [10:0] word_count0;
    logic        in_ready1, mem_we1, busy1, done1, error1, cpu_hold1;
    logic [9:0]  mem_addr1, mem_wdata1;
    logic [10:0] word_count1;

    imem_loader #(.FILL_HALT(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .busy(busy0), .done(done0), .error(error0), .cpu_hold(cpu_hold0), .word_count(word_count0)
    );

    imem_loader #(.FILL_HALT(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .busy(busy1), .done(done1), .error(error1), .cpu_hold(cpu_hold1), .word_count(word_count1)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    logic [9:0] m0 [1024];
    logic [9:0] m1 [1024];
    int         wr0 = 0, wr1 = 0, halt1 = 0, dn0 = 0, dn1 = 0;
    int         done_cyc0 = 0, done_cyc1 = 0, last_wr1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we0) begin
            m0[mem_addr0] <= mem_wdata0;
            wr0 <= wr0 + 1;
        end
        if (mem_we1) begin
            m1[mem_addr1] <= mem_wdata1;
            wr1 <= wr1 + 1;
            last_wr1 <= cyc;
            if (mem_wdata1 == HALT) halt1 <= halt1 + 1;
        end
        if (done0) begin
            dn0 <= dn0 + 1;
            done_cyc0 <= cyc;
        end
        if (done1) begin
            dn1 <= dn1 + 1;
            done_cyc1 <= cyc;
        end
    end

    int total = 0, bad = 0;
    int sc, b_wr0, b_wr1, b_h1, b_dn0, b_dn1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_wr0 = wr0; b_wr1 = wr1; b_h1 = halt1; b_dn0 = dn0; b_dn1 = dn1;
    endtask

    task automatic do_start();
        start = 1'b1;
        sc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [9:0] w, input bit gap);
        int t;
        in_valid = 1'b1;
        in_data  = w;
        t = 0;
        while (!in_ready0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("ready_timeout", 32'(t), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy0 || busy1) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", 32'(t < 3000), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, "_ctl0"}, {in_ready0, mem_we0, busy0, done0, error0, cpu_hold0}, 32'b000001);
        check({tag, "_dat0"}, {mem_addr0, mem_wdata0, word_count0}, 32'd0);
        check({tag, "_ctl1"}, {in_ready1, mem_we1, busy1, done1, error1, cpu_hold1}, 32'b000001);
        check({tag, "_dat1"}, {mem_addr1, mem_wdata1, word_count1}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);

        // good load, N=3, checksum 0x3FE
        snap();
        do_start();
        check("start_busy_rdy", {busy0, in_ready0, cpu_hold0}, 32'b111);
        send(10'd3, 0); send(10'h310, 0); send(10'h319, 0); send(10'h1D5, 0); send(10'h3FE, 0);
        wait_idle();
        check("g_wr0", 32'(wr0 - b_wr0), 32'd3);
        check("g_m0_0", 32'(m0[0]), 32'h310);
        check("g_m0_1", 32'(m0[1]), 32'h319);
        check("g_m0_2", 32'(m0[2]), 32'h1D5);
        check("g_done0", 32'(dn0 - b_dn0), 32'd1);
        check("g_lat0", 32'(done_cyc0 - sc), 32'd6);
        check("g_st0", {cpu_hold0, error0, busy0, 21'(word_count0)}, 32'd3);
        check("g_wr1", 32'(wr1 - b_wr1), 32'd1024);
        check("g_halt1", 32'(halt1 - b_h1), 32'd1021);
        check("g_m1_3", 32'(m1[3]), 32'(HALT));
        check("g_m1_top", 32'(m1[1023]), 32'(HALT));
        check("g_m1_2", 32'(m1[2]), 32'h1D5);
        check("g_done1", 32'(dn1 - b_dn1), 32'd1);
        check("g_lat1", 32'(done_cyc1 - sc), 32'd1027);
        check("g_lastfill1", 32'(done_cyc1 - last_wr1), 32'd1);
        check("g_hold1", {cpu_hold1, error1}, 32'b00);

        // bad checksum
        snap();
        do_start();
        check("b_hold_start", 32'(cpu_hold0), 32'd1);
        send(10'd1, 0); send(10'h0AB, 0); send(10'h0AC, 0);
        wait_idle();
        check("b_wr0", 32'(wr0 - b_wr0), 32'd1);
        check("b_m0_0", 32'(m0[0]), 32'h0AB);
        check("b_st0", {error0, cpu_hold0, busy0}, 32'b110);
        check("b_done0", 32'(dn0 - b_dn0), 32'd0);
        check("b_st1", {error1, cpu_hold1, busy1}, 32'b110);
        check("b_wr1", 32'(wr1 - b_wr1), 32'd1);

        // N=2 with in_valid toggling and a stray start mid-LOAD
        snap();
        do_start();
        check("bp_err_clr", 32'(error0), 32'd0);
        send(10'd2, 1);
        in_valid = 1'b0;
        send(10'h005, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("bp_busy_mid", {busy0, 21'(word_count0)}, 32'h200001);
        send(10'h007, 1);
        send(10'h00C, 1);
        wait_idle();
        check("bp_wr0", 32'(wr0 - b_wr0), 32'd2);
        check("bp_m0", {22'(m0[1]), m0[0]}, {22'h7, 10'h005});
        check("bp_done0", 32'(dn0 - b_dn0), 32'd1);
        check("bp_st0", {cpu_hold0, error0, 21'(word_count0)}, 32'd2);
        check("bp_wr1", 32'(wr1 - b_wr1), 32'd1024);

        // N=0, trailer 0
        snap();
        do_start();
        check("z_hold_start", 32'(cpu_hold0), 32'd1);
        send(10'd0, 0); send(10'd0, 0);
        wait_idle();
        check("z_wr0", 32'(wr0 - b_wr0), 32'd0);
        check("z_done0", 32'(dn0 - b_dn0), 32'd1);
        check("z_wc0", 32'(word_count0), 32'd0);
        check("z_halt1", 32'(halt1 - b_h1), 32'd1024);
        check("z_m1_0", 32'(m1[0]), 32'(HALT));
        check("z_done1", {cpu_hold1, 31'(dn1 - b_dn1)}, 32'd1);

        // reset after 2 of 5 payload words, then a full load
        do_start();
        send(10'd5, 0); send(10'h111, 0); send(10'h222, 0);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        reset = 1'b0;
        @(negedge clk);
        snap();
        do_start();
        send(10'd2, 0); send(10'h100, 0); send(10'h200, 0); send(10'h300, 0);
        wait_idle();
        check("r_wr0", 32'(wr0 - b_wr0), 32'd2);
        check("r_m0", {22'(m0[1]), m0[0]}, {22'h200, 10'h100});
        check("r_st0", {cpu_hold0, error0, 31'(dn0 - b_dn0)}, 32'd1);
        check("r_st1", {cpu_hold1, error1, 31'(dn1 - b_dn1)}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
